// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_if
//  Description : Line/consumer-side signal bundle of the serial_rx receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_rx_if;
  logic       rx_in;
  logic       read_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       error;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_in,
    output read_ack,
    input  data_out,
    input  data_valid,
    input  error,
    input  overrun,
    input  busy
  );

  modport slave (
    input  rx_in,
    input  read_ack,
    output data_out,
    output data_valid,
    output error,
    output overrun,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx
//  Description : 8N1 MSB-first serial receiver with mid-bit sampling, a
//                one-byte holding register and framing/overrun flags.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_rx #(
  parameter int DelayTime = 104
) (
  input  logic        clock,
  input  logic        reset,
  serial_rx_if.slave  bus
);

  localparam int         c_P      = DelayTime + 2;
  localparam int         c_H      = c_P / 2;
  localparam logic [6:0] c_P_LAST = 7'(c_P - 1);
  localparam logic [6:0] c_H_LAST = 7'(c_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     r_state, w_state_nx;
  logic [6:0] r_cnt, w_cnt_nx;
  logic [2:0] r_idx, w_idx_nx;
  logic [7:0] r_shreg, w_shreg_nx;
  logic       w_done;

  logic       r_sync1, r_rx_s;
  logic [1:0] r_fill;
  logic       r_armed;

  logic [7:0] r_data_out;
  logic       r_data_valid, r_error, r_overrun;

  logic       w_good, w_bad, w_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_in;
      r_rx_s  <= r_sync1;
    end
  end

  // After reset the synchronizer holds forced 1s; a start is only accepted once
  // a genuine idle level has come through, so an aborted frame's tail is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_fill != 2'd2)
        r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd2 && r_rx_s)
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 7'd0;
      r_idx   <= 3'd0;
      r_shreg <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shreg <= w_shreg_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shreg_nx = r_shreg;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx = 7'd0;
        if (r_armed && !r_rx_s)
          w_state_nx = START;
      end
      START: begin
        if (r_cnt == c_H_LAST) begin
          w_cnt_nx   = 7'd0;
          w_idx_nx   = 3'd0;
          w_state_nx = r_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nx = r_cnt + 7'd1;
        end
      end
      DATA: begin
        if (r_cnt == c_P_LAST) begin
          w_shreg_nx = {r_shreg[6:0], r_rx_s};
          w_cnt_nx   = 7'd0;
          w_idx_nx   = r_idx + 3'd1;
          if (r_idx == 3'd7)
            w_state_nx = STOP;
        end else begin
          w_cnt_nx = r_cnt + 7'd1;
        end
      end
      STOP: begin
        if (r_cnt == c_P_LAST) begin
          w_done     = 1'b1;
          w_cnt_nx   = 7'd0;
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + 7'd1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = 7'd0;
      end
    endcase
  end

  assign w_good = w_done &  r_rx_s;
  assign w_bad  = w_done & ~r_rx_s;
  assign w_ack  = bus.read_ack & r_data_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out   <= 8'd0;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_good && (!r_data_valid || bus.read_ack)) begin
        r_data_out   <= r_shreg;
        r_data_valid <= 1'b1;
        r_error      <= 1'b0;
        if (w_ack)
          r_overrun <= 1'b0;
      end else if (w_good) begin
        // Holding register still full and not being read: drop the new byte.
        r_overrun <= 1'b1;
        r_error   <= 1'b0;
      end else begin
        if (w_bad)
          r_error <= 1'b1;
        if (w_ack) begin
          r_data_valid <= 1'b0;
          r_overrun    <= 1'b0;
        end
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.error      = r_error;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter: DelayTime, 104, bit-period constant; one bit period P = DelayTime+2 = 106 clocks; half period H = P/2 = 53 clocks.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_in  input  1  asynchronous serial line; idle 1; frame is start 0, 8 data bits MSB first, stop 1.
REQ-005 read_ack  input  1  consumer accepts data_out; meaningful only while data_valid=1.
REQ-006 data_out  output  8  last correctly framed byte.
REQ-007 data_valid  output  1  holding register full; level, held until acknowledged.
REQ-008 error  output  1  framing error flag (stop bit sampled 0).
REQ-009 overrun  output  1  byte dropped because holding register was still full.
REQ-010 busy  output  1  1 whenever state != IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer; rx_s is the second stage, and all decisions SHALL use rx_s only.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; internal registers: 7-bit bit counter cnt, 3-bit bit index idx, 8-bit shift register shreg.
REQ-013 IDLE: rx_s=0 -> START with cnt=0; otherwise remain in IDLE.
REQ-014 START: cnt increments each cycle; at cnt=H-1 (52), rx_s=0 -> DATA with cnt=0, idx=0; rx_s=1 -> IDLE as a false start, with no flag change.
REQ-015 DATA: at cnt=P-1 (105), shreg <= {shreg[6:0], rx_s}, cnt=0, idx increments; when the 8th bit is sampled (idx=7) -> STOP; otherwise cnt increments.
REQ-016 STOP: at cnt=P-1, sample rx_s and return to IDLE in the same edge (completion cycle); otherwise cnt increments.
REQ-017 Completion with stop=1 and (data_valid=0 or read_ack=1): data_out<=shreg, data_valid<=1, error<=0.
REQ-018 Completion with stop=1, data_valid=1 and read_ack=0: overrun<=1; data_out and data_valid unchanged; new byte discarded; error<=0.
REQ-019 Completion with stop=0: error<=1; byte discarded; data_out/data_valid unchanged except by read_ack.
REQ-020 read_ack=1 while data_valid=1 SHALL clear data_valid and overrun on the next edge, unless REQ-017 loads a new byte in the same edge, in which case data_valid stays 1.
REQ-021 read_ack while data_valid=0 SHALL be ignored.
REQ-022 error SHALL remain set until the next good frame completes or reset.
REQ-023 Sampling points SHALL be H+P*k cycles after the start edge is seen on rx_s (mid-bit); data bit k is sampled P*(k+1)+H-1 cycles after entering START.
REQ-024 cnt SHALL never exceed P-1; no wrap-around is allowed in any state.

Reset
REQ-025 Reset SHALL force state=IDLE; cnt, idx and shreg to 0; both synchronizer flops to 1; data_out=0, data_valid=0, error=0, overrun=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no completion side effects; the remainder of that frame SHALL NOT be decoded as a new start unless rx_s later shows 1 then 0 from IDLE.

Verification
REQ-027 Send 0xA5 at P=106 with stop=1 -> data_out=0xA5, data_valid=1, error=0, overrun=0, busy=0 after the completion edge.
REQ-028 Drive a 10-cycle low glitch on idle rx_in -> busy pulses, then IDLE at START cnt=52; data_valid=0 and error=0.
REQ-029 Send 0x3C with stop bit 0 -> error=1, data_valid unchanged (0); then send 0x81 correctly -> data_out=0x81, error=0.
REQ-030 Send 0x11 then 0x22 with no read_ack -> data_out=0x11, data_valid=1, overrun=1; read_ack -> data_valid=0, overrun=0.
REQ-031 Hold read_ack=1 on the completion edge of 0x55 while 0x11 is pending -> data_out=0x55, data_valid=1, overrun=0.
REQ-032 Assert reset during DATA bit 4 of 0xF0 -> all outputs 0 next edge; then a full 0x0F frame -> data_out=0x0F.
